// File: rtl/stream_source_pkg.sv
// Shared types for the buffered sample transmitter: FSM state encoding and the
// default sample width.
package stream_source_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/stream_source_mem.sv
// Sample buffer: DEPTH x DATA_W register file, one synchronous write port and a
// registered read port whose output register is the streamed out_data.
module stream_source_mem
  import stream_source_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // The read register doubles as the out_data output, so it is cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/stream_source.sv
// Buffered sample transmitter: fills a frame through a write port in IDLE, then
// streams it in write order on a valid/ready interface; the frame can be replayed.
module stream_source
  import stream_source_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              busy,
  output logic              done
);

  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  state_e          state_q, state_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic            done_q, done_d;

  logic            mem_we;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic            is_full;
  logic            is_last;

  assign is_full = (count_q == CNT_DEPTH);
  assign is_last = ({1'b0, rd_ptr_q} == (count_q - CNT_ONE));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    mem_we      = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = rd_ptr_q + PTR_ONE;

    unique case (state_q)
      IDLE: begin
        // clr outranks start, which outranks wr_en; losers are dropped.
        if (clr) begin
          count_d = '0;
        end else if (start) begin
          if (count_q == '0) begin
            state_d = DONE;
          end else begin
            state_d     = STREAM;
            rd_ptr_d    = '0;
            rd_en       = 1'b1;
            rd_addr     = '0;
            out_valid_d = 1'b1;
          end
        end else if (wr_en && !is_full) begin
          mem_we  = !reset;
          count_d = count_q + CNT_ONE;
        end
      end
      STREAM: begin
        if (out_valid_q && out_ready) begin
          if (is_last) begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            rd_en    = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  stream_source_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mem_we),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (out_data)
  );

  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign full      = is_full;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_stream_source.sv
// Directed and randomized bench for stream_source (DEPTH=4) against a frame-level
// model: an array of stored samples plus a count.
module tb_stream_source;

  localparam int DW = 32;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    count;
  logic          full;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DP];
  int          model_cnt = 0;

  always #5 clk = ~clk;

  stream_source #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .start     (start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (model_cnt < DP) begin
      model_mem[model_cnt] = d;
      model_cnt++;
    end
    chk("wr_count", 32'(count), 32'(model_cnt));
    chk("wr_full", 32'(full), 32'(model_cnt == DP));
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low 3 cycles on beat 2
  task automatic run_stream(input int mode, input bit noise);
    logic [31:0] got [$];
    logic [31:0] prev_data;
    int          vcyc, stalls, cyc;
    bit          seen, prev_stall, rdy;
    got.delete();
    vcyc = 0; stalls = 0; cyc = 0; seen = 0; prev_stall = 0; prev_data = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_valid", 32'(out_valid), 32'(model_cnt > 0));
    for (int c = 0; c < 200 && !seen; c++) begin
      if (done) begin
        seen = 1;
        chk("done_no_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("cnt_in_stream", 32'(count), 32'(model_cnt));
        chk("valid_gap", 32'(out_valid), 32'd1);
        if (out_valid) begin
          vcyc++;
          if (prev_stall) chk("hold_data", out_data, prev_data);
          case (mode)
            0: rdy = 1'b1;
            1: rdy = ($urandom_range(0, 3) != 0);
            default: rdy = !(got.size() == 1 && stalls < 3);
          endcase
          if (!rdy) stalls++;
          out_ready = rdy;
          if (rdy) got.push_back(out_data);
          prev_stall = !rdy;
          prev_data  = out_data;
          if (noise) begin
            wr_en   = 1'($urandom_range(0, 1));
            start   = 1'($urandom_range(0, 1));
            clr     = 1'($urandom_range(0, 1));
            wr_data = $urandom;
          end
        end
        tick();
        cyc++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    out_ready = 1'b0;
    wr_en     = 1'b0;
    clr       = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("start_in_done_ignored", 32'(out_valid), 32'd0);
    chk("cnt_after_stream", 32'(count), 32'(model_cnt));
    chk("beat_total", 32'(got.size()), 32'(model_cnt));
    for (int i = 0; i < got.size() && i < model_cnt; i++) begin
      chk("beat_data", got[i], model_mem[i]);
    end
    if (mode == 0) begin
      chk("valid_cycles", 32'(vcyc), 32'(model_cnt));
      chk("frame_cycles", 32'(cyc), 32'(model_cnt));
    end
    if (mode == 2) chk("stall_cycles", 32'(stalls), 32'd3);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    // empty start: done next cycle, no data
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_valid", 32'(out_valid), 32'd0);
    tick();
    chk("empty_done_once", 32'(done), 32'd0);
    chk("empty_valid2", 32'(out_valid), 32'd0);
    chk("empty_idle", 32'(busy), 32'd0);

    // basic frame, then back-pressure replay, then noisy random-ready replay
    do_write(32'd5); do_write(32'd9); do_write(32'd3); do_write(32'd7);
    run_stream(0, 1'b0);
    run_stream(2, 1'b0);
    run_stream(1, 1'b1);

    // clr beats wr_en
    clr = 1'b1; wr_en = 1'b1; wr_data = 32'hDEAD;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    model_cnt = 0;
    chk("clr_wr_count", 32'(count), 32'd0);
    chk("clr_wr_full", 32'(full), 32'd0);

    // overfill: fifth write dropped
    for (int i = 1; i <= 5; i++) do_write(32'(i));
    run_stream(0, 1'b0);

    // randomized frames
    for (int r = 0; r < 4; r++) begin
      clr = 1'b1;
      tick();
      clr = 1'b0;
      model_cnt = 0;
      chk("rand_clr", 32'(count), 32'd0);
      for (int i = 0, n = $urandom_range(1, DP + 1); i < n; i++) do_write($urandom);
      run_stream(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset mid-frame after two beats
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < DP; i++) do_write($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    chk("mid_beat1", out_data, model_mem[0]);
    tick();
    chk("mid_beat2", out_data, model_mem[1]);
    tick();
    chk("mid_beat3_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    model_cnt = 0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_no_done", 32'(done), 32'd0);
      chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
    end

    // recovery after reset
    do_write(32'd11); do_write(32'd22);
    run_stream(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
